// File: rtl/ahb_arb_pkg.sv
// rtl/ahb_arb_pkg.sv - shared encodings and helpers for the round-robin AHB arbiter
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_LOCK = 2'b10
  } arb_state_e;

  // One-hot (up to 8 masters) to binary index; zero-padded callers are fine.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_rr_arbiter_if.sv
// rtl/ahb_rr_arbiter_if.sv - arbiter bus bundle; lock signals exist only with AHB_ARB_LOCK_EN
interface ahb_rr_arbiter_if #(
  parameter int NM = 4
);
  localparam int IW = $clog2(NM);

  logic [2*NM-1:0] HTRANS_M;
  logic            HREADY;
  logic [NM-1:0]   ADDR_SEL;
  logic [NM-1:0]   DATA_SEL;
  logic [IW-1:0]   HMASTER;
  logic [NM-1:0]   HREADY_M;
`ifdef AHB_ARB_LOCK_EN
  logic [NM-1:0]   HMASTLOCK_M;
  logic            HMASTLOCK;

  modport slave (
    input  HTRANS_M, HREADY, HMASTLOCK_M,
    output ADDR_SEL, DATA_SEL, HMASTER, HREADY_M, HMASTLOCK
  );
  modport master (
    output HTRANS_M, HREADY, HMASTLOCK_M,
    input  ADDR_SEL, DATA_SEL, HMASTER, HREADY_M, HMASTLOCK
  );
`else
  modport slave (
    input  HTRANS_M, HREADY,
    output ADDR_SEL, DATA_SEL, HMASTER, HREADY_M
  );
  modport master (
    output HTRANS_M, HREADY,
    input  ADDR_SEL, DATA_SEL, HMASTER, HREADY_M
  );
`endif

endinterface

// File: rtl/ahb_rr_pick.sv
// rtl/ahb_rr_pick.sv - rotate-priority picker scanning upward from last grant + 1
module ahb_rr_pick #(
  parameter int NM = 4
) (
  input  logic [NM-1:0] req,
  input  logic [NM-1:0] last,
  output logic [NM-1:0] gnt,
  output logic          valid
);

  int last_idx;

  // The last grantee is scanned last, so it only wins when nobody else asks.
  always_comb begin
    gnt      = '0;
    valid    = 1'b0;
    last_idx = 0;
    for (int i = 0; i < NM; i++) begin
      if (last[i]) last_idx = i;
    end
    for (int k = 1; k <= NM; k++) begin
      for (int j = 0; j < NM; j++) begin
        if (!valid && req[j] && (j == (last_idx + k) % NM)) begin
          gnt[j] = 1'b1;
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// rtl/ahb_rr_arbiter.sv - round-robin AHB-Lite arbiter; optional lock support via AHB_ARB_LOCK_EN
module ahb_rr_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NM   = 4,
  parameter int PARK = 0
) (
  input  logic             HCLK,
  input  logic             HRESET,
  ahb_rr_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NM);
  localparam logic [NM-1:0] PARK_OH = {{(NM-1){1'b0}}, 1'b1} << PARK;

  logic [NM-1:0] req;
  logic [NM-1:0] own_q, own_d;
  logic [NM-1:0] data_sel_q, data_sel_d;
  logic [NM-1:0] pick_gnt;
  logic          pick_valid;
  logic [NM-1:0] hready_m;
  logic [1:0]    owner_htrans;
  logic          owner_idle;
  logic          owner_lock;
  arb_state_e    state_q, state_d;

  ahb_rr_pick #(.NM(NM)) u_pick (
    .req   (req),
    .last  (own_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // Request decode and the current owner's transfer type.
  always_comb begin
    req          = '0;
    owner_htrans = HTRANS_IDLE;
    for (int i = 0; i < NM; i++) begin
      req[i] = bus.HTRANS_M[2*i+1];
      if (own_q[i]) owner_htrans = bus.HTRANS_M[2*i +: 2];
    end
  end

  assign owner_idle = (owner_htrans == HTRANS_IDLE);

`ifdef AHB_ARB_LOCK_EN
  assign owner_lock    = |(bus.HMASTLOCK_M & own_q);
  assign bus.HMASTLOCK = owner_lock;
`else
  assign owner_lock = 1'b0;
`endif

  // Grant/data-phase sequencing; everything freezes during wait states.
  always_comb begin
    own_d      = own_q;
    data_sel_d = data_sel_q;
    state_d    = state_q;
    if (bus.HREADY) begin
      data_sel_d = owner_htrans[1] ? own_q : '0;
      case (state_q)
        ST_LOCK: begin
          if (!owner_lock) begin
            state_d = owner_idle ? ST_IDLE : ST_XFER;
            if (owner_idle && pick_valid) own_d = pick_gnt;
          end
        end
        default: begin
          if (owner_idle && owner_lock) begin
            state_d = ST_LOCK;
          end else if (owner_idle) begin
            state_d = ST_IDLE;
            if (pick_valid) own_d = pick_gnt;
          end else begin
            state_d = ST_XFER;
          end
        end
      endcase
    end
  end

  // Owner, data owner and state registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      own_q      <= PARK_OH;
      data_sel_q <= '0;
      state_q    <= ST_IDLE;
    end else begin
      own_q      <= own_d;
      data_sel_q <= data_sel_d;
      state_q    <= state_d;
    end
  end

  // Per-master HREADY: bus owners see the slave, held requesters see a stall.
  always_comb begin
    hready_m = '0;
    for (int i = 0; i < NM; i++) begin
      if (own_q[i] || data_sel_q[i]) hready_m[i] = bus.HREADY;
      else if (req[i])               hready_m[i] = 1'b0;
      else                           hready_m[i] = 1'b1;
    end
  end

  assign bus.ADDR_SEL = own_q;
  assign bus.DATA_SEL = data_sel_q;
  assign bus.HMASTER  = IW'(onehot_to_idx(8'(own_q)));
  assign bus.HREADY_M = hready_m;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// tb/tb_ahb_rr_arbiter.sv - scoreboard bench for ahb_rr_arbiter (NM=4, PARK=0)
module tb_ahb_rr_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ahb_rr_arbiter_if #(.NM(4)) bus();

  ahb_rr_arbiter #(.NM(4), .PARK(0)) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus.slave)
  );

  typedef struct {
    string      nm;
    logic [3:0] as;
    logic [3:0] ds;
    logic [1:0] hm;
    logic [3:0] hrm;
    logic       lk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string nm, input string fld, input logic [3:0] act, input logic [3:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s.%s actual=%b required=%b", nm, fld, act, req_v);
    end
  endtask

  // Monitor: pops one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      cmp(mon_e.nm, "addr_sel", bus.ADDR_SEL, mon_e.as);
      cmp(mon_e.nm, "data_sel", bus.DATA_SEL, mon_e.ds);
      cmp(mon_e.nm, "hmaster",  {2'b00, bus.HMASTER}, {2'b00, mon_e.hm});
      cmp(mon_e.nm, "hready_m", bus.HREADY_M, mon_e.hrm);
`ifdef AHB_ARB_LOCK_EN
      cmp(mon_e.nm, "hmastlock", {3'b000, bus.HMASTLOCK}, {3'b000, mon_e.lk});
`endif
    end
  end

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic step(input string nm, input logic r, input logic [7:0] tr, input logic hr,
                      input logic [3:0] lk, input logic [3:0] eas, input logic [3:0] eds,
                      input logic [1:0] ehm, input logic [3:0] ehrm, input logic elk);
    exp_t e;
    rst          = r;
    bus.HTRANS_M = tr;
    bus.HREADY   = hr;
`ifdef AHB_ARB_LOCK_EN
    bus.HMASTLOCK_M = lk;
`else
    if (lk != 4'b0000) $display("note: lock stimulus ignored in %s", nm);
`endif
    e.nm  = nm;
    e.as  = eas;
    e.ds  = eds;
    e.hm  = ehm;
    e.hrm = ehrm;
    e.lk  = elk;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.HTRANS_M = '0;
    bus.HREADY   = 1'b1;
`ifdef AHB_ARB_LOCK_EN
    bus.HMASTLOCK_M = '0;
`endif
    repeat (2) @(posedge clk);
    #1;

    //   name               rst  htrans {m3,m2,m1,m0}  hr   lock     addr     data     hm     hready_m lk
    step("reset",           0, 8'b00_00_00_00, 1, 4'b0000, 4'b0001, 4'b0000, 2'd0, 4'b1111, 0);
    step("park_nonseq",     0, 8'b00_00_00_10, 1, 4'b0000, 4'b0001, 4'b0000, 2'd0, 4'b1111, 0);
    step("park_data",       0, 8'b00_00_00_00, 1, 4'b0000, 4'b0001, 4'b0001, 2'd0, 4'b1111, 0);
    step("m0_own",          0, 8'b00_10_10_10, 1, 4'b0000, 4'b0001, 4'b0000, 2'd0, 4'b1001, 0);
    step("m0_idle",         0, 8'b00_10_10_00, 1, 4'b0000, 4'b0001, 4'b0001, 2'd0, 4'b1001, 0);
    step("handover_m1",     0, 8'b00_10_10_00, 1, 4'b0000, 4'b0010, 4'b0000, 2'd1, 4'b1011, 0);
    step("m1_idle",         0, 8'b00_10_00_00, 1, 4'b0000, 4'b0010, 4'b0010, 2'd1, 4'b1011, 0);
    step("handover_m2",     0, 8'b00_10_00_00, 1, 4'b0000, 4'b0100, 4'b0000, 2'd2, 4'b1111, 0);
    step("wait1",           0, 8'b10_00_00_00, 0, 4'b0000, 4'b0100, 4'b0100, 2'd2, 4'b0011, 0);
    step("wait2",           0, 8'b10_00_00_00, 0, 4'b0000, 4'b0100, 4'b0100, 2'd2, 4'b0011, 0);
    step("wait3",           0, 8'b10_00_00_00, 0, 4'b0000, 4'b0100, 4'b0100, 2'd2, 4'b0011, 0);
    step("wait_release",    0, 8'b10_00_00_00, 1, 4'b0000, 4'b0100, 4'b0100, 2'd2, 4'b0111, 0);
    step("handover_m3",     0, 8'b10_00_00_00, 1, 4'b0000, 4'b1000, 4'b0000, 2'd3, 4'b1111, 0);
    step("m3_idle",         0, 8'b00_00_10_00, 1, 4'b0000, 4'b1000, 4'b1000, 2'd3, 4'b1101, 0);
    step("burst_b0",        0, 8'b00_00_10_10, 1, 4'b0000, 4'b0010, 4'b0000, 2'd1, 4'b1110, 0);
    step("burst_b1",        0, 8'b00_00_11_10, 1, 4'b0000, 4'b0010, 4'b0010, 2'd1, 4'b1110, 0);
    step("burst_b2",        0, 8'b00_00_11_10, 1, 4'b0000, 4'b0010, 4'b0010, 2'd1, 4'b1110, 0);
    step("burst_b3",        0, 8'b00_00_11_10, 1, 4'b0000, 4'b0010, 4'b0010, 2'd1, 4'b1110, 0);
    step("burst_last_data", 0, 8'b00_00_00_10, 1, 4'b0000, 4'b0010, 4'b0010, 2'd1, 4'b1110, 0);
    step("burst_end_m0",    0, 8'b00_00_00_10, 1, 4'b0000, 4'b0001, 4'b0000, 2'd0, 4'b1111, 0);
    step("busy_hold",       0, 8'b00_10_00_01, 1, 4'b0000, 4'b0001, 4'b0001, 2'd0, 4'b1011, 0);
    step("busy_keep",       0, 8'b00_10_00_00, 1, 4'b0000, 4'b0001, 4'b0000, 2'd0, 4'b1011, 0);
    step("after_busy",      0, 8'b00_00_00_00, 1, 4'b0000, 4'b0100, 4'b0000, 2'd2, 4'b1111, 0);
    step("m2_nonseq",       0, 8'b00_10_00_00, 1, 4'b0000, 4'b0100, 4'b0000, 2'd2, 4'b1111, 0);
    step("pre_reset",       1, 8'b00_11_00_00, 1, 4'b0000, 4'b0100, 4'b0100, 2'd2, 4'b1111, 0);
    step("post_reset",      0, 8'b00_11_00_00, 1, 4'b0000, 4'b0001, 4'b0000, 2'd0, 4'b1011, 0);
`ifdef AHB_ARB_LOCK_EN
    step("lock_rst",        1, 8'b00_00_00_00, 1, 4'b0000, 4'b0100, 4'b0000, 2'd2, 4'b1111, 0);
    step("lock_hold1",      0, 8'b10_00_00_00, 1, 4'b0001, 4'b0001, 4'b0000, 2'd0, 4'b0111, 1);
    step("lock_hold2",      0, 8'b10_00_00_00, 1, 4'b0001, 4'b0001, 4'b0000, 2'd0, 4'b0111, 1);
    step("lock_drop",       0, 8'b10_00_00_00, 1, 4'b0000, 4'b0001, 4'b0000, 2'd0, 4'b0111, 0);
    step("lock_handover",   0, 8'b10_00_00_00, 1, 4'b0000, 4'b1000, 4'b0000, 2'd3, 4'b1111, 0);
`endif

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_rr_arbiter.md
# ahb_rr_arbiter

Round-robin bus arbiter that shares one AHB-Lite slave port among NM masters. It is the sequencing and control half of a multi-master AHB layer: it tracks the address-phase owner and the data-phase owner, and produces the one-hot selects that drive an external address/write-data mux. It also gates each master's HREADY so that a non-granted master's pending transfer is held. Grant changes only at transfer boundaries, so bursts are never split.

## Interface
- NM, 4: number of masters (2..8).
- PARK, 0: index of the master that owns the bus after reset.
- HCLK  in  1  bus clock.
- HRESET  in  1  reset; synchronous, active-high.
- HTRANS_M  in  2*NM  per-master HTRANS; master i occupies bits [2i+1:2i].
- HREADY  in  1  HREADYOUT from the shared slave side.
- HMASTLOCK_M  in  NM  per-master lock request; present only with AHB_ARB_LOCK_EN.
- ADDR_SEL  out  NM  one-hot address-phase owner; steers HADDR/HTRANS/HWRITE/HSIZE.
- DATA_SEL  out  NM  one-hot data-phase owner (all-zero when no data phase); steers HWDATA.
- HMASTER  out  $clog2(NM)  binary index of ADDR_SEL.
- HREADY_M  out  NM  per-master HREADY.
- HMASTLOCK  out  1  forwarded lock of the owner; present only with AHB_ARB_LOCK_EN.

## Operation
- Request: req[i] = HTRANS_M[i][1] (NONSEQ or SEQ).
- Owner register `own` (one-hot) is always valid. When no master requests, the bus parks on the last owner.
- States:
  - ST_XFER: owner HTRANS ≠ IDLE.
  - ST_IDLE: owner presents IDLE.
  - ST_LOCK: owner presents IDLE with lock held (macro only).
- Re-arbitration edge: HREADY=1 and owner HTRANS=IDLE and not locked.
  - At that edge, `own` takes the round-robin pick over req, scanning from owner+1 (mod NM) upward.
  - If req is all-zero, `own` is unchanged.
  - The owner's own request never wins over a scan-earlier requester.
- Owner issuing NONSEQ, SEQ or BUSY keeps the grant. A master that never returns to IDLE starves the others; this is by design.
- Data phase: at each HREADY=1 edge, DATA_SEL takes `own` if the owner's HTRANS[1]=1, otherwise all-zero. DATA_SEL holds while HREADY=0.
- HREADY_M[i]:
  - HREADY, if ADDR_SEL[i] or DATA_SEL[i].
  - 0, if req[i] and i is neither owner nor data owner.
  - 1, otherwise.
- Simultaneous requests at the re-arbitration edge: exactly one winner per edge, by round-robin order.

## Timing
- Reset values: ADDR_SEL = 1<<PARK, HMASTER = PARK, DATA_SEL = 0, state = ST_IDLE, HMASTLOCK = 0. HREADY_M follows its combinational rule.
- Reset asserted mid-burst: all registers return to their reset values on the next edge; any in-flight transfer is abandoned.
- ADDR_SEL, DATA_SEL and HMASTER are registered. HREADY_M is combinational from HREADY, HTRANS_M and the registers.
- Handover latency: one cycle. The losing owner's IDLE cycle is the switch edge, and the new owner's held NONSEQ appears on the bus in the next cycle. No extra idle cycle is inserted.
- The parked owner issues with zero arbitration latency.
- Wait states: while HREADY=0, `own`, DATA_SEL and state are frozen.

## Configuration
- AHB_ARB_LOCK_EN defined:
  - HMASTLOCK_M and HMASTLOCK ports exist.
  - If HMASTLOCK_M[owner]=1 at a re-arbitration edge, the grant is retained and the state enters ST_LOCK.
  - The state leaves ST_LOCK at the first HREADY=1 edge with lock low, re-arbitrating there.
  - HMASTLOCK = HMASTLOCK_M[owner].
- Undefined: the lock ports are absent and ST_LOCK is unreachable. The grant is released at every owner-IDLE edge.

## Structure
- Package ahb_arb_pkg:
  - HTRANS encodings: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - State encodings for ST_IDLE, ST_XFER and ST_LOCK.
- Sub-module ahb_rr_pick: combinational rotate-priority picker. Inputs are req[NM] and the one-hot last grant; output is a one-hot winner plus a valid flag.
- The top level holds the state machine, the registers and the HREADY_M gating. The data mux is external.

## Test plan
- Reset, NM=4, PARK=0, all masters IDLE: ADDR_SEL=4'b0001, DATA_SEL=0, HMASTER=0, HREADY_M=4'b1111.
- M0 (parked) NONSEQ in cycle 1, HREADY=1: ADDR_SEL stays 0001, HREADY_M[0]=1, DATA_SEL=0001 in cycle 2.
- M0 owns; M1 and M2 request; M0 goes IDLE with HREADY=1 → ADDR_SEL=0010 next cycle, HREADY_M[2]=0. M1 goes IDLE → ADDR_SEL=0100.
- Owner IDLE with HREADY=0 for 3 cycles and M3 requesting → ADDR_SEL and DATA_SEL unchanged until HREADY rises; then ADDR_SEL=1000.
- M1 4-beat burst (NONSEQ, SEQ×3) while M0 requests throughout → ADDR_SEL stays 0010 for all beats, DATA_SEL=0010 until the last data phase completes.
- With AHB_ARB_LOCK_EN: M0 IDLE with HMASTLOCK_M[0]=1 and M3 requesting → ADDR_SEL stays 0001, HMASTLOCK=1. Lock drops → ADDR_SEL=1000 after the next HREADY=1 edge.
